operand_entry_ctrl: RTL and testbench

- Operator-input front end for the CPU board build: takes raw slide switches and push buttons, then issues a loaded operand/opcode command to the CPU.
- Works in the opposite direction to the hex-display output path. The display path renders CPU results to the operator; this block carries operator data into the CPU.
- Each button is synchronized and debounced to a single press event. Presses latch the switches into operand A, operand B or the opcode, or toggle carry-in.
- A "go" press hands the complete set to the CPU over a valid/ready handshake.

---
 rtl/operand_entry_ctrl.sv | 153 +++++++++++++++
 tb/tb_operand_entry_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : operand_entry_ctrl
// Purpose  : Debounced operator entry of operands/opcode, issued to the CPU
//            as one command over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module operand_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SW_W            = 10,
  parameter int DATA_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SW_W-1:0]   sw,
  input  logic              a_btn_n,
  input  logic              b_btn_n,
  input  logic              op_btn_n,
  input  logic              cin_btn_n,
  input  logic              go_btn_n,
  input  logic              cmd_ready,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [7:0]        op_out,
  output logic              cin_out,
  output logic              cmd_valid,
  output logic [2:0]        loaded,
  output logic              busy
);

  localparam int c_NBTN  = 5;
  localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int c_A   = 0;
  localparam int c_B   = 1;
  localparam int c_OP  = 2;
  localparam int c_CIN = 3;
  localparam int c_GO  = 4;

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_ISSUE   = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SW_W-1:0]     r_sw_s1;
  logic [SW_W-1:0]     r_sw_s2;
  logic [c_NBTN-1:0]   w_btn_raw;
  logic [c_NBTN-1:0]   r_btn_s1;
  logic [c_NBTN-1:0]   r_btn_s2;
  logic [c_NBTN-1:0]   r_stable;
  logic [c_NBTN-1:0]   r_stable_d;
  logic [c_NBTN-1:0]   r_strobe;
  logic [c_CNT_W-1:0]  r_cnt [c_NBTN];
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [7:0]          r_op;
  logic                r_cin;
  logic [2:0]          r_loaded;

  assign w_btn_raw = {go_btn_n, cin_btn_n, op_btn_n, b_btn_n, a_btn_n};

  // Released (1) is the idle level everywhere in the conditioning chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_s1    <= '1;
      r_sw_s2    <= '1;
      r_btn_s1   <= '1;
      r_btn_s2   <= '1;
      r_stable   <= '1;
      r_stable_d <= '1;
      r_strobe   <= '0;
      for (int i = 0; i < c_NBTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sw_s1    <= sw;
      r_sw_s2    <= r_sw_s1;
      r_btn_s1   <= w_btn_raw;
      r_btn_s2   <= r_btn_s1;
      r_stable_d <= r_stable;
      r_strobe   <= r_stable_d & ~r_stable;
      for (int i = 0; i < c_NBTN; i++) begin
        if (r_btn_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == c_CNT_LAST) begin
          r_stable[i] <= r_btn_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: if (r_strobe[c_GO] && (r_loaded == 3'b111)) w_state_nxt = S_ISSUE;
      S_ISSUE:   if (cmd_ready) w_state_nxt = S_COLLECT;
      default:   w_state_nxt = S_COLLECT;
    endcase
  end

  // Strobes arriving while a command is pending are dropped, not queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cin    <= 1'b0;
      r_loaded <= '0;
    end else if (r_state == S_COLLECT) begin
      if (r_strobe[c_A]) begin
        r_a         <= DATA_W'(r_sw_s2);
        r_loaded[0] <= 1'b1;
      end
      if (r_strobe[c_B]) begin
        r_b         <= DATA_W'(r_sw_s2);
        r_loaded[1] <= 1'b1;
      end
      if (r_strobe[c_OP]) begin
        r_op        <= r_sw_s2[7:0];
        r_loaded[2] <= 1'b1;
      end
      if (r_strobe[c_CIN]) begin
        r_cin <= ~r_cin;
      end
    end else if (cmd_ready) begin
      r_loaded <= '0;
    end
  end

  assign a_out     = r_a;
  assign b_out     = r_b;
  assign op_out    = r_op;
  assign cin_out   = r_cin;
  assign loaded    = r_loaded;
  assign cmd_valid = (r_state == S_ISSUE);
  assign busy      = (r_state == S_ISSUE);

endmodule
`default_nettype wire

// File: tb/tb_operand_entry_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_operand_entry_ctrl
// Purpose  : Directed and randomized bench for operand_entry_ctrl against a
//            sample-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_entry_ctrl;

  localparam int D    = 4;
  localparam int HMAX = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  sw;
  logic [4:0]  btn_n;   // {go, cin, op, b, a}, active-low
  logic        cmd_ready;
  logic [15:0] a_out, b_out;
  logic [7:0]  op_out;
  logic        cin_out, cmd_valid, busy;
  logic [2:0]  loaded;

  always #5 clk = ~clk;

  operand_entry_ctrl #(.DEBOUNCE_CYCLES(D), .SW_W(10), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .sw(sw),
    .a_btn_n(btn_n[0]), .b_btn_n(btn_n[1]), .op_btn_n(btn_n[2]),
    .cin_btn_n(btn_n[3]), .go_btn_n(btn_n[4]), .cmd_ready(cmd_ready),
    .a_out(a_out), .b_out(b_out), .op_out(op_out), .cin_out(cin_out),
    .cmd_valid(cmd_valid), .loaded(loaded), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a press is accepted once the raw button, seen two edges
  // late, has shown the new level for D consecutive samples; its effect
  // lands on the registers two edges after acceptance.
  int          edge_n = 0;
  int          base   = 0;
  logic [4:0]  bh  [HMAX];
  logic [9:0]  swh [HMAX];
  int          due [5];
  logic [4:0]  m_stable;
  logic [15:0] m_a, m_b;
  logic [7:0]  m_op;
  logic        m_cin, m_issue;
  logic [2:0]  m_loaded;

  function automatic logic bsample(int idx, int b);
    if (idx < base) return 1'b1;
    return bh[idx][b];
  endfunction

  always @(posedge clk) begin
    logic [9:0] swv;
    logic       go_ok, v, same;
    if (edge_n >= HMAX) begin
      $display("FAIL history_overflow: edge %0d limit %0d", edge_n, HMAX);
      $fatal(1);
    end
    if (reset) begin
      m_a = '0; m_b = '0; m_op = '0; m_cin = 1'b0; m_issue = 1'b0; m_loaded = '0;
      m_stable = '1;
      for (int b = 0; b < 5; b++) due[b] = -1;
      base = edge_n + 1;
    end else begin
      swv = (edge_n - 2 >= base) ? swh[edge_n-2] : 10'h3FF;
      if (m_issue) begin
        if (cmd_ready) begin
          m_issue  = 1'b0;
          m_loaded = '0;
        end
      end else begin
        go_ok = (due[4] == edge_n) && (m_loaded == 3'b111);
        if (due[0] == edge_n) begin m_a = {6'd0, swv}; m_loaded[0] = 1'b1; end
        if (due[1] == edge_n) begin m_b = {6'd0, swv}; m_loaded[1] = 1'b1; end
        if (due[2] == edge_n) begin m_op = swv[7:0];   m_loaded[2] = 1'b1; end
        if (due[3] == edge_n) m_cin = ~m_cin;
        if (go_ok) m_issue = 1'b1;
      end
      bh[edge_n]  = btn_n;
      swh[edge_n] = sw;
      for (int b = 0; b < 5; b++) begin
        v    = bsample(edge_n - 2, b);
        same = 1'b1;
        for (int k = 1; k < D; k++) if (bsample(edge_n - 2 - k, b) != v) same = 1'b0;
        if (same && (v != m_stable[b])) begin
          m_stable[b] = v;
          if (!v) due[b] = edge_n + 2;
        end
      end
    end
    edge_n++;
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: time %0t limit 1ms", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic handshake();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  // Press the buttons in mask together with sw held, then release long enough to re-arm.
  task automatic press(input logic [4:0] mask, input logic [9:0] swv, input int hold, input bit bounce);
    sw = swv;
    repeat (3) tick();
    if (bounce) begin
      repeat ($urandom_range(1, 3)) begin
        btn_n = ~mask; repeat ($urandom_range(1, D-1)) tick();
        btn_n = '1;    repeat ($urandom_range(1, D-1)) tick();
      end
    end
    btn_n = ~mask;
    repeat (hold) tick();
    if (bounce) begin
      btn_n = '1;    repeat ($urandom_range(1, D-1)) tick();
      btn_n = ~mask; repeat ($urandom_range(1, D-1)) tick();
    end
    btn_n = '1;
    repeat (D + 6) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({a_out, b_out, op_out, cin_out} !== 41'd0) begin
      errors++;
      $display("FAIL reset_data: got a=%h b=%h op=%h cin=%b want all 0", a_out, b_out, op_out, cin_out);
    end
    checks++;
    if ({cmd_valid, busy, loaded} !== 5'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got valid=%b busy=%b loaded=%b want 0", cmd_valid, busy, loaded);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_bounce();
    int cnt;
    sw = 10'h2A5;
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      btn_n[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) tick();
    end
    checks++;
    if ({a_out, loaded} !== 19'd0) begin
      errors++;
      $display("FAIL bounce_reject: got a=%h loaded=%b want 0000/000", a_out, loaded);
    end
    btn_n[0] = 1'b0;
    cnt = 0;
    while (a_out !== 16'h02A5 && cnt < 40) begin
      tick();
      cnt++;
    end
    // strobe at D+3 edges, register update one edge later
    checks++;
    if (cnt != D + 4) begin
      errors++;
      $display("FAIL bounce_latency: got %0d edges want %0d", cnt, D + 4);
    end
    checks++;
    if (loaded !== 3'b001) begin
      errors++;
      $display("FAIL bounce_loaded: got %b want 001", loaded);
    end
    sw = 10'h111;
    repeat (30) tick();
    checks++;
    if (a_out !== 16'h02A5) begin
      errors++;
      $display("FAIL bounce_single_strobe: got %h want 02a5", a_out);
    end
    btn_n[0] = 1'b1;
    repeat (D + 6) tick();
    checks++;
    if ({a_out, loaded} !== {m_a, m_loaded}) begin
      errors++;
      $display("FAIL bounce_model: got a=%h loaded=%b want a=%h loaded=%b", a_out, loaded, m_a, m_loaded);
    end
  endtask

  task automatic test_full_command();
    press(5'b00001, 10'h3FF, D + 6, 1'b0);
    press(5'b00010, 10'h001, D + 6, 1'b0);
    press(5'b00100, 10'h0C3, D + 6, 1'b0);
    press(5'b10000, 10'($urandom), D + 6, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({cmd_valid, busy, a_out, b_out, op_out} !== {1'b1, 1'b1, 16'h03FF, 16'h0001, 8'hC3}) begin
        errors++;
        $display("FAIL full_wait[%0d]: got valid=%b busy=%b a=%h b=%h op=%h want 1 1 03ff 0001 c3",
                 i, cmd_valid, busy, a_out, b_out, op_out);
      end
      tick();
    end
    handshake();
    checks++;
    if ({cmd_valid, busy, loaded, a_out} !== {1'b0, 1'b0, 3'b000, 16'h03FF}) begin
      errors++;
      $display("FAIL full_after_hs: got valid=%b busy=%b loaded=%b a=%h want 0 0 000 03ff",
               cmd_valid, busy, loaded, a_out);
    end
  endtask

  logic [9:0] exp_a;

  task automatic test_incomplete_go();
    logic [9:0] vb, vo;
    exp_a = 10'($urandom);
    vb    = 10'($urandom);
    vo    = 10'($urandom);
    press(5'b00001, exp_a, D + 6, 1'b1);
    press(5'b00010, vb, D + 6, 1'b1);
    press(5'b10000, 10'h000, D + 6, 1'b0);
    checks++;
    if ({cmd_valid, loaded} !== 4'b0_011) begin
      errors++;
      $display("FAIL incomplete_go: got valid=%b loaded=%b want 0 011", cmd_valid, loaded);
    end
    press(5'b00100, vo, D + 6, 1'b1);
    press(5'b10000, 10'h000, D + 6, 1'b0);
    checks++;
    if ({cmd_valid, a_out, b_out, op_out} !== {1'b1, 6'd0, exp_a, 6'd0, vb, vo[7:0]}) begin
      errors++;
      $display("FAIL complete_go: got valid=%b a=%h b=%h op=%h want 1 %h %h %h",
               cmd_valid, a_out, b_out, op_out, exp_a, vb, vo[7:0]);
    end
  endtask

  task automatic test_frozen();
    press(5'b01001, 10'h055, D + 6, 1'b0);
    checks++;
    if ({cmd_valid, a_out, cin_out} !== {1'b1, 6'd0, exp_a, 1'b0}) begin
      errors++;
      $display("FAIL frozen_busy: got valid=%b a=%h cin=%b want 1 %h 0", cmd_valid, a_out, cin_out, exp_a);
    end
    handshake();
    repeat (10) tick();
    checks++;
    if ({cmd_valid, loaded, a_out, cin_out} !== {1'b0, 3'b000, 6'd0, exp_a, 1'b0}) begin
      errors++;
      $display("FAIL frozen_no_defer: got valid=%b loaded=%b a=%h cin=%b want 0 000 %h 0",
               cmd_valid, loaded, a_out, cin_out, exp_a);
    end
  endtask

  task automatic test_simultaneous_final_load();
    press(5'b00011, 10'h2F0, D + 6, 1'b0);
    press(5'b10100, 10'h05A, D + 6, 1'b0);
    checks++;
    if ({cmd_valid, loaded, a_out, op_out} !== {1'b0, 3'b111, 16'h02F0, 8'h5A}) begin
      errors++;
      $display("FAIL same_cycle_go: got valid=%b loaded=%b a=%h op=%h want 0 111 02f0 5a",
               cmd_valid, loaded, a_out, op_out);
    end
    press(5'b10000, 10'h000, D + 6, 1'b0);
    checks++;
    if (cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL second_go: got valid=%b want 1", cmd_valid);
    end
    handshake();
  endtask

  task automatic test_carry();
    press(5'b01000, 10'h000, D + 6, 1'b1);
    checks++;
    if (cin_out !== 1'b1) begin
      errors++;
      $display("FAIL carry_first: got %b want 1", cin_out);
    end
    press(5'b01000, 10'h000, D + 6, 1'b1);
    checks++;
    if (cin_out !== 1'b0) begin
      errors++;
      $display("FAIL carry_second: got %b want 0", cin_out);
    end
    press(5'b01000, 10'h000, 50, 1'b0);
    checks++;
    if (cin_out !== 1'b1) begin
      errors++;
      $display("FAIL carry_held: got %b want 1", cin_out);
    end
  endtask

  task automatic test_reset_mid_issue();
    press(5'b00111, 10'h123, D + 6, 1'b0);
    press(5'b10000, 10'h000, D + 6, 1'b0);
    checks++;
    if (cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_issue_setup: got valid=%b want 1", cmd_valid);
    end
    btn_n[4] = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({a_out, b_out, op_out, cin_out, cmd_valid, loaded, busy} !== 46'd0) begin
      errors++;
      $display("FAIL mid_issue_reset: got a=%h b=%h op=%h cin=%b valid=%b loaded=%b busy=%b want all 0",
               a_out, b_out, op_out, cin_out, cmd_valid, loaded, busy);
    end
    tick();
    reset = 1'b0;
    repeat (D + 10) tick();
    checks++;
    if ({cmd_valid, busy, loaded} !== 5'd0 || m_issue !== 1'b0) begin
      errors++;
      $display("FAIL held_go_after_reset: got valid=%b busy=%b loaded=%b want 0 0 000", cmd_valid, busy, loaded);
    end
    btn_n[4] = 1'b1;
    repeat (D + 6) tick();
  endtask

  task automatic test_random();
    logic [4:0] mask;
    for (int it = 0; it < 12; it++) begin
      handshake();
      mask = 5'($urandom_range(1, 15));
      press(mask, 10'($urandom), D + 4 + $urandom_range(0, 6), 1'($urandom));
      if ($urandom_range(0, 1) == 1) press(5'b10000, 10'($urandom), D + 6, 1'($urandom));
      checks++;
      if ({a_out, b_out, op_out, cin_out, cmd_valid, busy, loaded} !==
          {m_a, m_b, m_op, m_cin, m_issue, m_issue, m_loaded}) begin
        errors++;
        $display("FAIL random[%0d]: got a=%h b=%h op=%h cin=%b v=%b busy=%b ld=%b want a=%h b=%h op=%h cin=%b v=%b ld=%b",
                 it, a_out, b_out, op_out, cin_out, cmd_valid, busy, loaded,
                 m_a, m_b, m_op, m_cin, m_issue, m_loaded);
      end
      if (m_issue) begin
        repeat ($urandom_range(0, 5)) tick();
        handshake();
        checks++;
        if ({cmd_valid, loaded} !== {m_issue, m_loaded} || m_issue !== 1'b0) begin
          errors++;
          $display("FAIL random_hs[%0d]: got valid=%b loaded=%b want 0 000", it, cmd_valid, loaded);
        end
      end
    end
  endtask

  initial begin
    btn_n     = '1;
    sw        = '0;
    cmd_ready = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    test_reset();
    test_bounce();
    test_full_command();
    test_incomplete_go();
    test_frozen();
    test_simultaneous_final_load();
    test_carry();
    test_reset_mid_issue();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
